// File: rtl/y1_pkg.sv
// Shared types and constants for the y1 product-term match scheduler.
// Holds the FSM state encoding, reset term and a width helper.
package y1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_e;

  localparam logic [15:0] RST_MASK  = 16'hFFF8;
  localparam logic [15:0] RST_VALUE = 16'h4628;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/y1_term_match.sv
// Single mask/value product term: hit when every masked bit
// of the word equals the corresponding value bit.
module y1_term_match #(
  parameter int W = 16
) (
  input  logic [W-1:0] word_i,
  input  logic [W-1:0] mask_i,
  input  logic [W-1:0] value_i,
  output logic         hit_o
);

  assign hit_o = &(~((word_i ^ value_i) & mask_i));

endmodule

// File: rtl/y1_match_sched.sv
// Round-robin scheduler sharing one product-term matcher among
// NREQ requesters, with a programmable term and hit/eval counters.
module y1_match_sched #(
  parameter int             NREQ      = 4,
  parameter int             W         = 16,
  parameter int             CNT_W     = 16,
  parameter logic [W-1:0]   RST_MASK  = y1_pkg::RST_MASK,
  parameter logic [W-1:0]   RST_VALUE = y1_pkg::RST_VALUE,
  localparam int            IDW       = y1_pkg::clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_hit,
  input  logic              cfg_we,
  input  logic [W-1:0]      cfg_mask,
  input  logic [W-1:0]      cfg_value,
  output logic              cfg_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  eval_cnt
);

  import y1_pkg::*;

  state_e           state_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   rr_d;
  logic [IDW-1:0]   cap_id_q;
  logic [IDW-1:0]   resp_id_q;
  logic [W-1:0]     word_q;
  logic [W-1:0]     mask_q;
  logic [W-1:0]     value_q;
  logic             resp_valid_q;
  logic             resp_hit_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] eval_q;

  logic             gnt_en;
  logic             gnt_any;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [W-1:0]     gnt_word;
  logic             hit;

  // A config write in IDLE takes the cycle; grants wait one cycle.
  assign gnt_en = (state_q == IDLE && !cfg_we) ||
                  (state_q == RESP && resp_ready);

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (gnt_en && !gnt_any && req_valid[j]) begin
        gnt[j]  = 1'b1;
        gnt_id  = IDW'(j);
        gnt_any = 1'b1;
      end
    end
  end

  assign gnt_word = req_data[int'(gnt_id)*W +: W];
  assign rr_d     = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;

  y1_term_match #(
    .W(W)
  ) u_term (
    .word_i (word_q),
    .mask_i (mask_q),
    .value_i(value_q),
    .hit_o  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      cap_id_q     <= '0;
      resp_id_q    <= '0;
      word_q       <= '0;
      mask_q       <= RST_MASK;
      value_q      <= RST_VALUE;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      hit_q        <= '0;
      eval_q       <= '0;
    end else begin
      if (cfg_we && state_q == IDLE) begin
        mask_q  <= cfg_mask;
        value_q <= cfg_value;
      end
      if (gnt_any) begin
        word_q   <= gnt_word;
        cap_id_q <= gnt_id;
        rr_q     <= rr_d;
      end
      unique case (state_q)
        IDLE: begin
          if (gnt_any) state_q <= EVAL;
        end
        EVAL: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit;
          resp_id_q    <= cap_id_q;
          if (~&eval_q) eval_q <= eval_q + 1'b1;
          if (hit && ~&hit_q) hit_q <= hit_q + 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= gnt_any ? EVAL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_hit   = resp_hit_q;
  assign cfg_ready  = (state_q == IDLE);
  assign hit_cnt    = hit_q;
  assign eval_cnt   = eval_q;

endmodule

// File: tb/tb_y1_match_sched.sv
// Directed bench for y1_match_sched: vector table plus
// hand-written arbitration, stall, config and reset sequences.
module tb_y1_match_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic              resp_ready;
  logic              cfg_we;
  logic [W-1:0]      cfg_mask;
  logic [W-1:0]      cfg_value;

  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic              resp_hit;
  logic              cfg_ready;
  logic [15:0]       hit_cnt;
  logic [15:0]       eval_cnt;

  logic [NREQ-1:0]   req_ready4;
  logic              resp_valid4;
  logic [1:0]        resp_id4;
  logic              resp_hit4;
  logic              cfg_ready4;
  logic [3:0]        hit_cnt4;
  logic [3:0]        eval_cnt4;

  int checks   = 0;
  int failures = 0;
  int m_eval   = 0;
  int m_hit    = 0;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        hit;
  } vec_t;

  vec_t tbl[6];
  int   order[5];

  y1_match_sched #(.NREQ(NREQ), .W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_hit(resp_hit),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .cfg_value(cfg_value), .cfg_ready(cfg_ready),
    .hit_cnt(hit_cnt), .eval_cnt(eval_cnt)
  );

  y1_match_sched #(.NREQ(NREQ), .W(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_id(resp_id4), .resp_hit(resp_hit4),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .cfg_value(cfg_value), .cfg_ready(cfg_ready4),
    .hit_cnt(hit_cnt4), .eval_cnt(eval_cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_cnts(input string nm);
    chk({nm, "_eval"},  32'(eval_cnt),  32'(sat(m_eval, 16)));
    chk({nm, "_hit"},   32'(hit_cnt),   32'(sat(m_hit, 16)));
    chk({nm, "_eval4"}, 32'(eval_cnt4), 32'(sat(m_eval, 4)));
    chk({nm, "_hit4"},  32'(hit_cnt4),  32'(sat(m_hit, 4)));
  endtask

  task automatic set_lane(input int i, input logic [15:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    cfg_we     = 1'b0;
    step();
    step();
    rst    = 1'b0;
    m_eval = 0;
    m_hit  = 0;
  endtask

  // From IDLE: one request, one response, back to IDLE.
  task automatic one_op(input int idx, input logic [15:0] d,
                        input logic h, input string nm);
    logic [3:0] oh;
    oh         = 4'(1 << idx);
    req_valid  = oh;
    set_lane(idx, d);
    resp_ready = 1'b1;
    #1;
    chk({nm, "_grant"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    #1;
    chk({nm, "_evalvalid"}, 32'(resp_valid), 32'd0);
    step();
    #1;
    m_eval++;
    if (h) m_hit++;
    chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, "_id"},    32'(resp_id),    32'(idx));
    chk({nm, "_hit"},   32'(resp_hit),   32'(h));
    check_cnts(nm);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    resp_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_mask  = '0;
    cfg_value = '0;

    tbl[0] = '{0, 16'h4628, 1'b1};
    tbl[1] = '{1, 16'h4629, 1'b1};
    tbl[2] = '{2, 16'h4668, 1'b0};
    tbl[3] = '{3, 16'h462F, 1'b1};
    tbl[4] = '{0, 16'hC628, 1'b0};
    tbl[5] = '{1, 16'h4620, 1'b0};
    order  = '{0, 1, 2, 3, 0};

    apply_reset();
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_resp_hit",   32'(resp_hit),   32'd0);
    chk("rst_cfg_ready",  32'(cfg_ready),  32'd1);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    check_cnts("rst");

    for (int i = 0; i < 6; i++) begin
      one_op(tbl[i].idx, tbl[i].data, tbl[i].hit,
             $sformatf("vec%0d", i));
    end

    // Round-robin with all requesters active and no backpressure.
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 16'h4628);
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    chk("rr_first", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk($sformatf("rr%0d_eval_nogrant", k), 32'(req_ready), 32'd0);
      chk($sformatf("rr%0d_eval_valid", k), 32'(resp_valid), 32'd0);
      step();
      if (k == 4) req_valid = '0;
      #1;
      m_eval++;
      m_hit++;
      chk($sformatf("rr%0d_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("rr%0d_id", k), 32'(resp_id), 32'(order[k]));
      if (k < 4) begin
        chk($sformatf("rr%0d_next", k), 32'(req_ready),
            32'(1 << order[k+1]));
      end
    end
    check_cnts("rr_end");
    step();

    // Backpressure: response held, no grants while stalled.
    set_lane(0, 16'h4628);
    set_lane(1, 16'h4668);
    set_lane(3, 16'h4628);
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    #1;
    chk("stall_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1001;
    #1;
    chk("stall_eval_nogrant", 32'(req_ready), 32'd0);
    step();
    #1;
    m_eval++;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d_valid", s), 32'(resp_valid), 32'd1);
      chk($sformatf("stall%0d_id", s),    32'(resp_id),    32'd1);
      chk($sformatf("stall%0d_hit", s),   32'(resp_hit),   32'd0);
      chk($sformatf("stall%0d_ready", s), 32'(req_ready),  32'd0);
      step();
      #1;
    end
    check_cnts("stall");
    resp_ready = 1'b1;
    #1;
    chk("stall_release_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    #1;
    chk("stall_release_eval", 32'(resp_valid), 32'd0);
    step();
    #1;
    m_eval++;
    m_hit++;
    chk("stall_release_id",  32'(resp_id),  32'd3);
    chk("stall_release_hit", 32'(resp_hit), 32'd1);
    step();

    // Config write while busy is dropped.
    req_valid  = 4'b0001;
    set_lane(0, 16'h4628);
    resp_ready = 1'b0;
    #1;
    chk("cfgbusy_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    cfg_we    = 1'b1;
    cfg_mask  = 16'h00FF;
    cfg_value = 16'h0012;
    #1;
    m_eval++;
    m_hit++;
    chk("cfgbusy_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("cfgbusy_hit",       32'(resp_hit),  32'd1);
    step();
    cfg_we     = 1'b0;
    resp_ready = 1'b1;
    step();
    one_op(0, 16'h4628, 1'b1, "cfg_ignored");

    // Config write colliding with a request in IDLE.
    req_valid  = 4'b0001;
    set_lane(0, 16'hAB12);
    cfg_we     = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("coll_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("coll_deferred",  32'(req_ready), 32'd0);
    step();
    cfg_we = 1'b0;
    #1;
    chk("coll_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    #1;
    m_eval++;
    m_hit++;
    chk("coll_valid", 32'(resp_valid), 32'd1);
    chk("coll_hit",   32'(resp_hit),   32'd1);
    step();

    // Twenty more ops drive the 4-bit counters into saturation.
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) one_op(k % 4, 16'h5512, 1'b1, $sformatf("sat%0d", k));
      else            one_op(k % 4, 16'h0013, 1'b0, $sformatf("sat%0d", k));
    end
    chk("sat_eval4_full", 32'(eval_cnt4), 32'hF);
    chk("sat_hit4_full",  32'(hit_cnt4),  32'hF);

    // Reset during EVAL discards the in-flight operation.
    req_valid  = 4'b0001;
    set_lane(0, 16'h0012);
    resp_ready = 1'b1;
    #1;
    chk("rstmid_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst    = 1'b0;
    m_eval = 0;
    m_hit  = 0;
    #1;
    chk("rstmid_valid",  32'(resp_valid),  32'd0);
    chk("rstmid_valid4", 32'(resp_valid4), 32'd0);
    chk("rstmid_cfg",    32'(cfg_ready),   32'd1);
    check_cnts("rstmid");
    step();
    #1;
    chk("rstmid_after_valid", 32'(resp_valid), 32'd0);
    one_op(0, 16'h4628, 1'b1, "post_rst_default");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
